// File: rtl/pwm_dec_pkg.sv
// Shared types and defaults for the PWM duty decoder.
//   dec_state_e     : decoder FSM states (ACQ, TRACK, LOCK)
//   DEF_FRAME_LOG2  : default window length exponent (64-cycle window)
//   DEF_LOCK_FRAMES : default number of consecutive equal windows for lock
//   match_w()       : width of the match counter for a given lock depth
package pwm_dec_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } dec_state_e;

  localparam int DEF_FRAME_LOG2  = 6;
  localparam int DEF_LOCK_FRAMES = 2;

  // Match counter only needs to reach LOCK_FRAMES-1; keep at least 1 bit.
  function automatic int match_w(input int lock_frames);
    return (lock_frames < 2) ? 1 : $clog2(lock_frames);
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// Multi-stage flop synchronizer for asynchronous inputs.
//   sysclk : destination clock
//   rst_n  : asynchronous active-low reset, clears all stages to 0
//   din    : asynchronous input bits (WIDTH)
//   dout   : synchronized bits, STAGES cycles of latency
module pulse_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], din};
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty value of an asynchronous PWM stream by counting high
// samples over a free-running 2^FRAME_LOG2-cycle window, and tracks lock when
// LOCK_FRAMES consecutive windows agree.
//   sysclk     : clock
//   rst_n      : asynchronous active-low reset
//   Pulse_In   : PWM stream, asynchronous to sysclk
//   Duty_Out   : recovered duty (high cycles per window, saturated)
//   Duty_Valid : one-cycle strobe when Duty_Out updates
//   Locked     : recovered duty stable for LOCK_FRAMES windows
//   Stuck_High : last window was high on every cycle
// Optional build macro PWM_DEC_AVG_EN: Duty_Out becomes the truncated mean of
// the last 4 window counts; lock detection still uses raw counts.
module pwm_duty_decoder
  import pwm_dec_pkg::*;
#(
  parameter int FRAME_LOG2  = DEF_FRAME_LOG2,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  Pulse_In,
  output logic [FRAME_LOG2-1:0] Duty_Out,
  output logic                  Duty_Valid,
  output logic                  Locked,
  output logic                  Stuck_High
);

  localparam int CW = FRAME_LOG2 + 1;  // window count range 0..2^FRAME_LOG2
  localparam int MW = match_w(LOCK_FRAMES);

  dec_state_e            state;
  logic                  pulse_s;
  logic [FRAME_LOG2-1:0] frame_cnt;
  logic [CW-1:0]         acc, win_cnt, prev_cnt;
  logic                  prev_vld;
  logic [MW-1:0]         match_cnt, match_inc;
  logic                  frame_end, win_full, same, lock_hit;
  logic [FRAME_LOG2-1:0] win_duty;

  pulse_sync #(.WIDTH(1), .STAGES(2)) u_sync (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .din    (Pulse_In),
    .dout   (pulse_s)
  );

  // Window count includes the sample of the frame-end cycle itself.
  assign frame_end = &frame_cnt;
  assign win_cnt   = acc + CW'(pulse_s);
  assign win_full  = win_cnt[FRAME_LOG2];
  assign win_duty  = win_full ? '1 : win_cnt[FRAME_LOG2-1:0];

  // prev_vld keeps the first reported window from matching the reset value.
  assign same      = prev_vld && (win_cnt == prev_cnt);
  assign match_inc = (int'(match_cnt) >= LOCK_FRAMES - 1) ? match_cnt
                                                          : match_cnt + MW'(1);
  // match_cnt+1 is the number of equal pairs including this window, so the
  // run of equal windows is match_cnt+2 when same.
  assign lock_hit  = (LOCK_FRAMES <= 1) ||
                     (same && (int'(match_cnt) + 1 >= LOCK_FRAMES - 1));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      acc       <= '0;
    end else begin
      frame_cnt <= frame_cnt + FRAME_LOG2'(1);
      acc       <= frame_end ? '0 : win_cnt;
    end
  end

`ifdef PWM_DEC_AVG_EN
  logic [2:0][CW-1:0] hist;
  logic [1:0]         hist_n;
  logic [CW+1:0]      avg_sum;
  logic [CW-1:0]      avg;
  logic               avg_rdy;

  // Current window plus the three before it.
  assign avg_sum = {2'b00, hist[0]} + {2'b00, hist[1]} +
                   {2'b00, hist[2]} + {2'b00, win_cnt};
  assign avg     = CW'(avg_sum >> 2);
  assign avg_rdy = (hist_n == 2'd3);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      hist_n <= '0;
    end else if (frame_end && state != ACQ) begin
      hist <= {hist[1:0], win_cnt};
      if (!avg_rdy) hist_n <= hist_n + 2'd1;
    end
  end
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQ;
      Locked     <= 1'b0;
      Duty_Out   <= '0;
      Duty_Valid <= 1'b0;
      Stuck_High <= 1'b0;
      prev_cnt   <= '0;
      prev_vld   <= 1'b0;
      match_cnt  <= '0;
    end else begin
      Duty_Valid <= 1'b0;
      if (frame_end) begin
        case (state)
          // First window holds synchronizer reset zeros: drop it.
          ACQ: state <= TRACK;
          default: begin
            prev_cnt   <= win_cnt;
            prev_vld   <= 1'b1;
            match_cnt  <= same ? match_inc : '0;
            state      <= lock_hit ? LOCK : TRACK;
            Locked     <= lock_hit;
            Stuck_High <= win_full;
`ifdef PWM_DEC_AVG_EN
            if (avg_rdy) begin
              Duty_Out   <= avg[FRAME_LOG2] ? '1 : avg[FRAME_LOG2-1:0];
              Duty_Valid <= 1'b1;
            end
`else
            Duty_Out   <= win_duty;
            Duty_Valid <= 1'b1;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized bench for pwm_duty_decoder. A reference model derives each
// window's high-sample count from the driven PWM history (two-cycle sampling
// delay, zeros right after reset), then applies the reporting and lock rules.
module tb_pwm_duty_decoder;

  localparam int FL = 6;
  localparam int LF = 2;
  localparam int N  = 1 << FL;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          Pulse_In;
  logic [FL-1:0] Duty_Out;
  logic          Duty_Valid, Locked, Stuck_High;

  pwm_duty_decoder #(.FRAME_LOG2(FL), .LOCK_FRAMES(LF)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .Pulse_In   (Pulse_In),
    .Duty_Out   (Duty_Out),
    .Duty_Valid (Duty_Valid),
    .Locked     (Locked),
    .Stuck_High (Stuck_High)
  );

  always #5 sysclk = ~sysclk;

  int vec_cnt = 0;
  int miscmp  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model state
  int ii;            // cycle index since reset release
  int t_glb = 0;     // transmitter time base (free of reset)
  bit d1, d2;        // drive history: one and two cycles back
  int acc_m, fidx, nvalid, last_win, run;
  int wins[$];
  int exp_duty, exp_vld, exp_lock, exp_stk;

  task automatic model_init();
    ii = 0; d1 = 0; d2 = 0; acc_m = 0; fidx = 0;
    nvalid = 0; last_win = 0; run = 0; wins.delete();
    exp_duty = 0; exp_vld = 0; exp_lock = 0; exp_stk = 0;
  endtask

  task automatic frame_done(input int win);
    int s;
    exp_vld = 0;
    if (fidx > 0) begin
      run = (nvalid > 0 && win == last_win) ? run + 1 : 1;
      last_win = win;
      nvalid++;
      exp_lock = (run >= LF);
      exp_stk  = (win == N);
`ifdef PWM_DEC_AVG_EN
      wins.push_back(win);
      if (wins.size() > 4) void'(wins.pop_front());
      if (wins.size() == 4) begin
        s = 0;
        foreach (wins[k]) s += wins[k];
        exp_duty = (s / 4 > N - 1) ? N - 1 : s / 4;
        exp_vld  = 1;
      end
`else
      s = win;
      exp_duty = (s > N - 1) ? N - 1 : s;
      exp_vld  = 1;
`endif
    end
    fidx++;
  endtask

  // Drive one cycle of Pulse_In, advance the model, check after the edge.
  task automatic step(input bit p);
    bit smp;
    Pulse_In = p;
    smp = d2;
    d2 = d1; d1 = p;
    acc_m += int'(smp);
    if (ii % N == N - 1) begin
      frame_done(acc_m);
      acc_m = 0;
    end else begin
      exp_vld = 0;
    end
    @(posedge sysclk); #1;
    ii++; t_glb++;
    chk("valid",  32'(Duty_Valid), 32'(exp_vld));
    chk("duty",   32'(Duty_Out),   32'(exp_duty));
    chk("locked", 32'(Locked),     32'(exp_lock));
    chk("stuck",  32'(Stuck_High), 32'(exp_stk));
  endtask

  task automatic run_pwm(input int d, input int ph, input int ncyc);
    for (int c = 0; c < ncyc; c++) step(((t_glb + ph) % N) < d);
  endtask

  task automatic run_rand(input int ncyc);
    for (int c = 0; c < ncyc; c++) step(1'($urandom_range(0, 1)));
  endtask

  // Asynchronous assert between edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_duty",   32'(Duty_Out),   32'd0);
    chk("rst_valid",  32'(Duty_Valid), 32'd0);
    chk("rst_locked", 32'(Locked),     32'd0);
    chk("rst_stuck",  32'(Stuck_High), 32'd0);
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    model_init();
  endtask

  initial begin
    int ph, d;
    rst_n = 1'b1;
    Pulse_In = 1'b0;
    #1;

    // Steady duty 20, arbitrary phase
    do_reset();
    run_pwm(20, $urandom_range(0, N - 1), N * 5);

    // Held low, then held high (saturation and stuck flag)
    do_reset();
    run_pwm(0, 0, N * 4);
    run_pwm(N, 0, N * 4);

    // Step 20 -> 45 at a random point in a window
    do_reset();
    ph = $urandom_range(0, N - 1);
    run_pwm(20, ph, N * 4 + $urandom_range(1, N - 1));
    run_pwm(45, ph, N * 5);

    // Reset mid-window with a held-high history
    do_reset();
    run_pwm(N, 0, N * 3 + $urandom_range(5, 50));
    do_reset();
    run_pwm(33, $urandom_range(0, N - 1), N * 4);

    // Randomized segments: random duty/phase, occasional random bit noise
    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 0) do_reset();
      for (int sgm = 0; sgm < 3; sgm++) begin
        d  = $urandom_range(0, N);
        ph = $urandom_range(0, N - 1);
        if ($urandom_range(0, 4) == 0) run_rand($urandom_range(N, 2 * N));
        else                           run_pwm(d, ph, $urandom_range(2 * N, 4 * N));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
